// File: rtl/axis_rx_latency_stats_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_rx_latency_stats_pkg : shared widths, FSM encoding, saturating helper
// Rev 1.0
// ---------------------------------------------------------------------------
package axis_rx_latency_stats_pkg;

  localparam int unsigned TIMESTAMP_WIDTH_DFLT = 64;
  localparam int unsigned SUM_WIDTH_DFLT       = 80;
  localparam int unsigned TS_OFFSET_DFLT       = 0;

  // Width of the saturating event counters (pkt_count, neg_count).
  localparam int unsigned CNT_WIDTH = 32;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [0:0] {
    ST_SOP  = 1'b0,
    ST_BODY = 1'b1
  } rx_state_e;

  function automatic logic [CNT_WIDTH-1:0] sat_inc_cnt(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

endpackage : axis_rx_latency_stats_pkg
`default_nettype wire

// File: rtl/axis_rx_latency_stats_accum.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rx_lat_accum : latency subtract, negative detect and saturating stats update
// Rev 1.0
// ---------------------------------------------------------------------------
module rx_lat_accum
  import axis_rx_latency_stats_pkg::*;
#(
  parameter int TIMESTAMP_WIDTH = TIMESTAMP_WIDTH_DFLT,
  parameter int SUM_WIDTH       = SUM_WIDTH_DFLT
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       v1_i,
  input  logic [TIMESTAMP_WIDTH-1:0] ts_i,
  input  logic [TIMESTAMP_WIDTH-1:0] cnt_i,
  output logic [CNT_WIDTH-1:0]       pkt_count_o,
  output logic [TIMESTAMP_WIDTH-1:0] lat_last_o,
  output logic [TIMESTAMP_WIDTH-1:0] lat_min_o,
  output logic [TIMESTAMP_WIDTH-1:0] lat_max_o,
  output logic [SUM_WIDTH-1:0]       lat_sum_o,
  output logic [CNT_WIDTH-1:0]       neg_count_o,
  output logic                       stats_update_o
);

  logic                       v2_q;
  logic [TIMESTAMP_WIDTH-1:0] diff_q;

  logic [CNT_WIDTH-1:0]       pkt_q,  pkt_d;
  logic [CNT_WIDTH-1:0]       neg_q,  neg_d;
  logic [TIMESTAMP_WIDTH-1:0] last_q, last_d;
  logic [TIMESTAMP_WIDTH-1:0] min_q,  min_d;
  logic [TIMESTAMP_WIDTH-1:0] max_q,  max_d;
  logic [SUM_WIDTH-1:0]       sum_q,  sum_d;
  logic                       upd_q,  upd_d;

  logic [SUM_WIDTH:0]         sum_ext;
  logic                       diff_neg;

  // Modular subtract: a small latency across a stamp_counter wrap stays positive.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      v2_q   <= 1'b0;
      diff_q <= '0;
    end else begin
      v2_q   <= v1_i;
      diff_q <= cnt_i - ts_i;
    end
  end

  assign diff_neg = diff_q[TIMESTAMP_WIDTH-1];
  assign sum_ext  = {1'b0, sum_q} + (SUM_WIDTH+1)'(diff_q);

  always_comb begin
    pkt_d  = pkt_q;
    neg_d  = neg_q;
    last_d = last_q;
    min_d  = min_q;
    max_d  = max_q;
    sum_d  = sum_q;
    upd_d  = 1'b0;
    if (v2_q) begin
      upd_d = 1'b1;
      if (diff_neg) begin
        neg_d = sat_inc_cnt(neg_q);
      end else begin
        pkt_d  = sat_inc_cnt(pkt_q);
        last_d = diff_q;
        if (diff_q < min_q) min_d = diff_q;
        if (diff_q > max_q) max_d = diff_q;
        sum_d  = sum_ext[SUM_WIDTH] ? '1 : sum_ext[SUM_WIDTH-1:0];
      end
    end
  end

  // A clear in the same cycle as an update wins.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      pkt_q  <= '0;
      neg_q  <= '0;
      last_q <= '0;
      min_q  <= '1;
      max_q  <= '0;
      sum_q  <= '0;
      upd_q  <= 1'b0;
    end else begin
      pkt_q  <= pkt_d;
      neg_q  <= neg_d;
      last_q <= last_d;
      min_q  <= min_d;
      max_q  <= max_d;
      sum_q  <= sum_d;
      upd_q  <= upd_d;
    end
  end

  assign pkt_count_o    = pkt_q;
  assign neg_count_o    = neg_q;
  assign lat_last_o     = last_q;
  assign lat_min_o      = min_q;
  assign lat_max_o      = max_q;
  assign lat_sum_o      = sum_q;
  assign stats_update_o = upd_q;

endmodule : rx_lat_accum
`default_nettype wire

// File: rtl/axis_rx_latency_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axis_rx_latency_stats : loopback RX sink measuring one-way packet latency
// Rev 1.0
// ---------------------------------------------------------------------------
module axis_rx_latency_stats
  import axis_rx_latency_stats_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int TIMESTAMP_WIDTH      = TIMESTAMP_WIDTH_DFLT,
  parameter int TS_OFFSET            = TS_OFFSET_DFLT,
  parameter int SUM_WIDTH            = SUM_WIDTH_DFLT
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                              S_AXIS_TVALID,
  output logic                              S_AXIS_TREADY,
  input  logic                              S_AXIS_TLAST,
  input  logic [TIMESTAMP_WIDTH-1:0]        stamp_counter,
  input  logic                              ext_rst_count,
  input  logic                              ext_gate_ctrl,
  output logic                              armed,
  output logic [CNT_WIDTH-1:0]              pkt_count,
  output logic [TIMESTAMP_WIDTH-1:0]        lat_last,
  output logic [TIMESTAMP_WIDTH-1:0]        lat_min,
  output logic [TIMESTAMP_WIDTH-1:0]        lat_max,
  output logic [SUM_WIDTH-1:0]              lat_sum,
  output logic [CNT_WIDTH-1:0]              neg_count,
  output logic                              stats_update
);

  logic                       tready_q;
  logic                       armed_q;
  rx_state_e                  state_q, state_d;
  logic                       v1_q;
  logic [TIMESTAMP_WIDTH-1:0] ts_q;
  logic [TIMESTAMP_WIDTH-1:0] cnt_q;
  logic                       accept;
  logic                       unused_sideband;

  assign unused_sideband = ^{S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TDATA};
  assign accept          = S_AXIS_TVALID & tready_q;

  // The sink never back-pressures except for the one cycle after a clear.
  always_ff @(posedge ACLK) begin
    if (ARESET) tready_q <= 1'b0;
    else        tready_q <= ~ext_rst_count;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET || ext_rst_count) armed_q <= 1'b0;
    else if (ext_gate_ctrl)      armed_q <= 1'b1;
  end

  // Framing survives a stats clear; only ARESET returns it to SOP.
  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_SOP;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_SOP:  if (accept && !S_AXIS_TLAST) state_d = ST_BODY;
      ST_BODY: if (accept &&  S_AXIS_TLAST) state_d = ST_SOP;
      default: state_d = ST_SOP;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      v1_q  <= 1'b0;
      ts_q  <= '0;
      cnt_q <= '0;
    end else begin
      v1_q <= accept && (state_q == ST_SOP) && armed_q && !ext_rst_count;
      if (accept) begin
        ts_q  <= S_AXIS_TDATA[TS_OFFSET +: TIMESTAMP_WIDTH];
        cnt_q <= stamp_counter;
      end
    end
  end

  rx_lat_accum #(
    .TIMESTAMP_WIDTH (TIMESTAMP_WIDTH),
    .SUM_WIDTH       (SUM_WIDTH)
  ) u_accum (
    .clk_i          (ACLK),
    .rst_i          (ARESET),
    .clr_i          (ext_rst_count),
    .v1_i           (v1_q),
    .ts_i           (ts_q),
    .cnt_i          (cnt_q),
    .pkt_count_o    (pkt_count),
    .lat_last_o     (lat_last),
    .lat_min_o      (lat_min),
    .lat_max_o      (lat_max),
    .lat_sum_o      (lat_sum),
    .neg_count_o    (neg_count),
    .stats_update_o (stats_update)
  );

  assign S_AXIS_TREADY = tready_q;
  assign armed         = armed_q;

endmodule : axis_rx_latency_stats
`default_nettype wire

// File: tb/tb_axis_rx_latency_stats.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_axis_rx_latency_stats : directed + randomized bench with reference model
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_axis_rx_latency_stats;

  localparam int DW   = 256;
  localparam int UW   = 128;
  localparam int TW   = 64;
  localparam int TOFS = 0;
  localparam int SW   = 80;

  logic            ACLK = 1'b0;
  logic            ARESET = 1'b1;
  logic [DW-1:0]   S_AXIS_TDATA = '0;
  logic [DW/8-1:0] S_AXIS_TSTRB = '1;
  logic [UW-1:0]   S_AXIS_TUSER = '0;
  logic            S_AXIS_TVALID = 1'b0;
  logic            S_AXIS_TREADY;
  logic            S_AXIS_TLAST = 1'b0;
  logic [TW-1:0]   stamp_counter = '0;
  logic            ext_rst_count = 1'b0;
  logic            ext_gate_ctrl = 1'b0;
  logic            armed;
  logic [31:0]     pkt_count;
  logic [TW-1:0]   lat_last, lat_min, lat_max;
  logic [SW-1:0]   lat_sum;
  logic [31:0]     neg_count;
  logic            stats_update;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;
  logic preload_pkt = 1'b0;

  always #5 ACLK = ~ACLK;

  axis_rx_latency_stats #(
    .C_S_AXIS_DATA_WIDTH (DW),
    .C_S_AXIS_TUSER_WIDTH(UW),
    .TIMESTAMP_WIDTH     (TW),
    .TS_OFFSET           (TOFS),
    .SUM_WIDTH           (SW)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TSTRB  (S_AXIS_TSTRB),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .stamp_counter (stamp_counter),
    .ext_rst_count (ext_rst_count),
    .ext_gate_ctrl (ext_gate_ctrl),
    .armed         (armed),
    .pkt_count     (pkt_count),
    .lat_last      (lat_last),
    .lat_min       (lat_min),
    .lat_max       (lat_max),
    .lat_sum       (lat_sum),
    .neg_count     (neg_count),
    .stats_update  (stats_update)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model: packet-level, edge-indexed ----------------
  typedef struct {
    int          due;
    logic [TW-1:0] diff;
  } pend_t;

  pend_t         pq[$];
  int            edge_n = 0;
  logic          m_tready = 1'b0, m_armed = 1'b0, m_inpkt = 1'b0, m_upd = 1'b0;
  logic [31:0]   m_pkt = '0, m_neg = '0;
  logic [TW-1:0] m_last = '0, m_min = '1, m_max = '0;
  logic [SW-1:0] m_sum = '0;
  logic [SW:0]   m_tmp;
  logic          m_acc;

  task m_clear_stats();
    m_pkt = '0; m_neg = '0; m_last = '0; m_min = '1; m_max = '0; m_sum = '0;
    m_upd = 1'b0;
    pq.delete();
  endtask

  task m_apply(input logic [TW-1:0] d);
    if (d[TW-1]) begin
      if (m_neg != 32'hFFFF_FFFF) m_neg = m_neg + 1;
    end else begin
      if (m_pkt != 32'hFFFF_FFFF) m_pkt = m_pkt + 1;
      m_last = d;
      if (d < m_min) m_min = d;
      if (d > m_max) m_max = d;
      m_tmp = {1'b0, m_sum} + {{(SW+1-TW){1'b0}}, d};
      m_sum = m_tmp[SW] ? '1 : m_tmp[SW-1:0];
    end
  endtask

  always @(posedge ACLK) begin
    edge_n = edge_n + 1;
    m_upd  = 1'b0;
    if (ARESET) begin
      m_tready = 1'b0; m_armed = 1'b0; m_inpkt = 1'b0;
      m_clear_stats();
    end else begin
      m_acc = S_AXIS_TVALID && m_tready;
      if (ext_rst_count) begin
        m_clear_stats();
        m_armed  = 1'b0;
        m_tready = 1'b0;
      end else begin
        if (pq.size() > 0 && pq[0].due == edge_n) begin
          m_apply(pq[0].diff);
          void'(pq.pop_front());
          m_upd = 1'b1;
        end
        if (m_acc && !m_inpkt && m_armed)
          pq.push_back('{edge_n + 2, stamp_counter - S_AXIS_TDATA[TOFS +: TW]});
        if (ext_gate_ctrl) m_armed = 1'b1;
        m_tready = 1'b1;
      end
      if (m_acc) m_inpkt = !S_AXIS_TLAST;
      if (preload_pkt) m_pkt = '1;
    end
  end

  always @(negedge ACLK) begin
    if (chk_en) begin
      check("tready",    S_AXIS_TREADY, m_tready);
      check("armed",     armed,         m_armed);
      check("pkt_count", pkt_count,     m_pkt);
      check("neg_count", neg_count,     m_neg);
      check("lat_last",  lat_last,      m_last);
      check("lat_min",   lat_min,       m_min);
      check("lat_max",   lat_max,       m_max);
      check("lat_sum",   lat_sum,       m_sum);
      check("stats_upd", stats_update,  m_upd);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] make_data(input logic [TW-1:0] ts);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = $urandom;
    d[TOFS +: TW] = ts;
    return d;
  endfunction

  task automatic send_beat(input logic [TW-1:0] ts, input logic [TW-1:0] stamp,
                           input logic last, input logic gate, input logic clr);
    int n = 0;
    @(negedge ACLK);
    S_AXIS_TDATA  = make_data(ts);
    stamp_counter = stamp;
    S_AXIS_TLAST  = last;
    S_AXIS_TVALID = 1'b1;
    ext_gate_ctrl = gate;
    ext_rst_count = clr;
    while (!S_AXIS_TREADY) begin
      if (n >= 20) begin
        check("tready_wait", 1'b0, 1'b1);
        break;
      end
      @(negedge ACLK);
      ext_gate_ctrl = 1'b0;
      ext_rst_count = 1'b0;
      n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0; S_AXIS_TLAST = 1'b0;
      ext_gate_ctrl = 1'b0; ext_rst_count = 1'b0;
    end
  endtask

  task automatic pulse_gate();
    @(negedge ACLK); S_AXIS_TVALID = 1'b0; ext_gate_ctrl = 1'b1;
    @(negedge ACLK); ext_gate_ctrl = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge ACLK); S_AXIS_TVALID = 1'b0; ext_rst_count = 1'b1;
    @(negedge ACLK); ext_rst_count = 1'b0;
  endtask

  int lats[4] = '{10, 50, 5, 20};

  initial begin
    @(posedge ACLK);
    chk_en = 1'b1;
    idle(3);
    check("rst_min", lat_min, {TW{1'b1}});
    check("rst_tready", S_AXIS_TREADY, 1'b0);
    ARESET = 1'b0;
    idle(1);

    // single 3-beat packet, latency 30
    pulse_gate();
    send_beat(64'd100, 64'd130, 1'b0, 1'b0, 1'b0);
    send_beat(64'd7,   64'd131, 1'b0, 1'b0, 1'b0);
    send_beat(64'd9,   64'd132, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t1_pkt", pkt_count, 32'd1);
    check("t1_last", lat_last, 64'd30);
    check("t1_min", lat_min, 64'd30);
    check("t1_max", lat_max, 64'd30);
    check("t1_sum", lat_sum, 80'd30);

    // four back-to-back single-beat packets
    pulse_clear();
    pulse_gate();
    for (int i = 0; i < 4; i++)
      send_beat(64'(1000 + i - lats[i]), 64'(1000 + i), 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t2_pkt", pkt_count, 32'd4);
    check("t2_min", lat_min, 64'd5);
    check("t2_max", lat_max, 64'd50);
    check("t2_sum", lat_sum, 80'd85);

    // unarmed packet, then arming mid-packet
    pulse_clear();
    send_beat(64'd10, 64'd20, 1'b0, 1'b0, 1'b0);
    send_beat(64'd10, 64'd21, 1'b1, 1'b0, 1'b0);
    send_beat(64'd10, 64'd30, 1'b0, 1'b0, 1'b0);
    send_beat(64'd10, 64'd31, 1'b0, 1'b1, 1'b0);
    send_beat(64'd10, 64'd32, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t3_pkt0", pkt_count, 32'd0);
    check("t3_armed", armed, 1'b1);
    send_beat(64'd40, 64'd49, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t3_pkt1", pkt_count, 32'd1);

    // negative and wrap-around latency
    send_beat(64'd200, 64'd150, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t4_neg", neg_count, 32'd1);
    check("t4_pkt", pkt_count, 32'd1);
    send_beat(64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t4_wrap_last", lat_last, 64'd8);
    check("t4_wrap_neg", neg_count, 32'd1);

    // clear one cycle after SOP acceptance
    send_beat(64'd60, 64'd100, 1'b0, 1'b0, 1'b0);
    send_beat(64'd60, 64'd101, 1'b1, 1'b0, 1'b1);
    idle(1);
    check("t5_tready", S_AXIS_TREADY, 1'b0);
    check("t5_armed", armed, 1'b0);
    check("t5_min", lat_min, {TW{1'b1}});
    idle(3);
    check("t5_pkt", pkt_count, 32'd0);
    pulse_gate();
    send_beat(64'd89, 64'd100, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t5_after", lat_last, 64'd11);

    // saturated pkt_count still updates lat_last
    @(negedge ACLK); preload_pkt = 1'b1;
    @(posedge ACLK); #1;
    force dut.u_accum.pkt_q = 32'hFFFF_FFFF;
    preload_pkt = 1'b0;
    @(negedge ACLK);
    release dut.u_accum.pkt_q;
    send_beat(64'd500, 64'd507, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t6_sat", pkt_count, 32'hFFFF_FFFF);
    check("t6_last", lat_last, 64'd7);

    // ARESET mid-BODY
    send_beat(64'd1, 64'd2, 1'b0, 1'b0, 1'b0);
    @(negedge ACLK); S_AXIS_TVALID = 1'b0; ARESET = 1'b1;
    @(negedge ACLK);
    check("t6_rst_pkt", pkt_count, 32'd0);
    check("t6_rst_min", lat_min, {TW{1'b1}});
    ARESET = 1'b0;
    idle(1);
    pulse_gate();
    send_beat(64'd500, 64'd512, 1'b1, 1'b0, 1'b0);
    idle(3);
    check("t6_sop_pkt", pkt_count, 32'd1);
    check("t6_sop_last", lat_last, 64'd12);

    // randomized phase, stamp_counter crosses its wrap point
    stamp_counter = 64'hFFFF_FFFF_FFFF_FC00;
    for (int c = 0; c < 3000; c++) begin
      @(negedge ACLK);
      stamp_counter = stamp_counter + 1;
      S_AXIS_TVALID = ($urandom % 10) < 7;
      S_AXIS_TLAST  = ($urandom % 10) < 4;
      case ($urandom % 20)
        0, 1:    S_AXIS_TDATA = make_data(stamp_counter + 64'($urandom % 500) + 1);
        2:       S_AXIS_TDATA = make_data({$urandom, $urandom});
        default: S_AXIS_TDATA = make_data(stamp_counter - 64'($urandom % 2000));
      endcase
      ext_gate_ctrl = ($urandom % 20) == 0;
      ext_rst_count = ($urandom % 150) == 0;
      ARESET        = ($urandom % 400) == 0;
    end
    ARESET = 1'b0;
    idle(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_axis_rx_latency_stats
`default_nettype wire
